regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and request type for the register-file writeback arbiter.
package riscv_wb_pkg;

  localparam int NUM_WB_PORTS = 2;
  localparam int PORT_ALU     = 0;
  localparam int PORT_MEM     = 1;
  localparam int ZERO_REG     = 0;
  localparam int WB_DATA_W    = 32;
  localparam int WB_ADDR_W    = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_data;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, busy
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; force1_i hands the grant to port 1 regardless of history.
module rr_arbiter2
  import riscv_wb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_WB_PORTS-1:0] req_i,
  input  logic                    force1_i,
  output logic [NUM_WB_PORTS-1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_o      = '0;
    last_grant_d = last_grant_q;
    if (force1_i && req_i[PORT_MEM]) begin
      grant_o[PORT_MEM] = 1'b1;
    end else if (&req_i) begin
      if (last_grant_q) grant_o[PORT_ALU] = 1'b1;
      else              grant_o[PORT_MEM] = 1'b1;
    end else begin
      grant_o = req_i;
    end
    if (grant_o[PORT_MEM])      last_grant_d = 1'b1;
    else if (grant_o[PORT_ALU]) last_grant_d = 1'b0;
  end

  // Resetting to 1 gives port 0 the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter feeding the register-file write port from the ALU and MEM stages.
// Optional decode forwarding taps are built when RF_WB_BYPASS_EN is defined.
module regfile_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]    byp_addr1,
  input  logic [ADDR_W-1:0]    byp_addr2,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [DATA_W-1:0]    byp_data
`endif
);

  logic [NUM_WB_PORTS-1:0] nz_valid;
  logic [NUM_WB_PORTS-1:0] zero_drop;
  logic [NUM_WB_PORTS-1:0] grant;
  logic                    same_addr;
  wb_req_t                 sel;

  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Writes to x0 are acknowledged immediately and never compete for the port.
  always_comb begin
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      zero_drop[p] = bus.req_valid[p] && (bus.req_addr[p] == ADDR_W'(ZERO_REG));
      nz_valid[p]  = bus.req_valid[p] && (bus.req_addr[p] != ADDR_W'(ZERO_REG));
    end
  end

  // MEM is older in program order, so it must land first when both target one register.
  assign same_addr = (&nz_valid) && (bus.req_addr[PORT_ALU] == bus.req_addr[PORT_MEM]);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (nz_valid),
    .force1_i (same_addr),
    .grant_o  (grant)
  );

  assign bus.req_ready = rst_n ? (grant | zero_drop) : '0;
  assign bus.busy      = rst_n && (|(nz_valid & ~grant));

  always_comb begin
    sel.addr  = bus.req_addr[PORT_ALU];
    sel.data  = bus.req_data[PORT_ALU];
    if (grant[PORT_MEM]) begin
      sel.addr = bus.req_addr[PORT_MEM];
      sel.data = bus.req_data[PORT_MEM];
    end
    wr_en_d   = |grant;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (|grant) begin
      wr_addr_d = sel.addr;
      wr_data_d = sel.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1 = wr_en_q && (wr_addr_q != ADDR_W'(ZERO_REG)) && (wr_addr_q == byp_addr1);
  assign byp_hit2 = wr_en_q && (wr_addr_q != ADDR_W'(ZERO_REG)) && (wr_addr_q == byp_addr2);
  assign byp_data = rst_n ? wr_data_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter, with a small register-file model.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] rf [32];
  logic        x0Written;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

`ifdef RF_WB_BYPASS_EN
  logic [4:0]  bypAddr1;
  logic [4:0]  bypAddr2;
  logic        bypHit1;
  logic        bypHit2;
  logic [31:0] bypData;
`endif

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef RF_WB_BYPASS_EN
    ,
    .byp_addr1 (bypAddr1),
    .byp_addr2 (bypAddr2),
    .byp_hit1  (bypHit1),
    .byp_hit2  (bypHit2),
    .byp_data  (bypData)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    x0Written = 1'b0;
  end

  // Behaves like the register file sitting on the write port.
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      rf[bus.wr_addr] <= bus.wr_data;
      if (bus.wr_addr == 5'd0) x0Written <= 1'b1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_addr[0] = 5'd3;
    bus.req_addr[1] = 5'd7;
    bus.req_data[0] = 32'hA;
    bus.req_data[1] = 32'hB;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=00", bus.req_ready); end
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL reset_wr_addr got=%0d exp=0", bus.wr_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL release_ready got=%b exp=01", bus.req_ready); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL release_busy got=%b exp=1", bus.busy); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_single_alu();
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_addr[0] = 5'd5;
    bus.req_data[0] = 32'hDEADBEEF;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_ready got=%b exp=01", bus.req_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    total++; if (bus.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL single_wr_en got=%b exp=1", bus.wr_en); end
    total++; if (bus.wr_addr !== 5'd5) begin bad++; $display("[TB] FAIL single_wr_addr got=%0d exp=5", bus.wr_addr); end
    total++; if (bus.wr_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_wr_data got=%h exp=deadbeef", bus.wr_data); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL idle_wr_en got=%b exp=0", bus.wr_en); end
    total++; if (bus.wr_addr !== 5'd5) begin bad++; $display("[TB] FAIL idle_wr_addr_hold got=%0d exp=5", bus.wr_addr); end
    total++; if (bus.wr_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL idle_wr_data_hold got=%h exp=deadbeef", bus.wr_data); end
  endtask

  task automatic test_contention();
    logic [1:0] validSeq [4];
    logic [1:0] readySeq [4];
    logic       busySeq  [4];
    logic [4:0] addrSeq  [4];
    validSeq = '{2'b11, 2'b11, 2'b11, 2'b10};
    readySeq = '{2'b01, 2'b10, 2'b01, 2'b10};
    busySeq  = '{1'b1, 1'b1, 1'b1, 1'b0};
    addrSeq  = '{5'd3, 5'd7, 5'd3, 5'd7};
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    bus.req_addr[0] = 5'd3;
    bus.req_addr[1] = 5'd7;
    bus.req_data[0] = 32'h33;
    bus.req_data[1] = 32'h77;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = validSeq[k];
      #1;
      total++; if (bus.req_ready !== readySeq[k]) begin bad++; $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready, readySeq[k]); end
      total++; if (bus.busy !== busySeq[k]) begin bad++; $display("[TB] FAIL rr_busy[%0d] got=%b exp=%b", k, bus.busy, busySeq[k]); end
      @(posedge clk); #1;
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL rr_wr_en[%0d] got=%b exp=1", k, bus.wr_en); end
      total++; if (bus.wr_addr !== addrSeq[k]) begin bad++; $display("[TB] FAIL rr_wr_addr[%0d] got=%0d exp=%0d", k, bus.wr_addr, addrSeq[k]); end
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_addr[0] = 5'd9;
    bus.req_addr[1] = 5'd9;
    bus.req_data[0] = 32'h11;
    bus.req_data[1] = 32'h22;
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("[TB] FAIL same_ready_first got=%b exp=10", bus.req_ready); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL same_busy_first got=%b exp=1", bus.busy); end
    @(posedge clk); #1;
    total++; if (bus.wr_data !== 32'h22) begin bad++; $display("[TB] FAIL same_wr_data_first got=%h exp=22", bus.wr_data); end
    total++; if (bus.wr_addr !== 5'd9) begin bad++; $display("[TB] FAIL same_wr_addr_first got=%0d exp=9", bus.wr_addr); end
    @(negedge clk);
    bus.req_valid = 2'b01;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL same_ready_second got=%b exp=01", bus.req_ready); end
    @(posedge clk); #1;
    total++; if (bus.wr_data !== 32'h11) begin bad++; $display("[TB] FAIL same_wr_data_second got=%h exp=11", bus.wr_data); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    total++; if (rf[9] !== 32'h11) begin bad++; $display("[TB] FAIL same_reg9_final got=%h exp=11", rf[9]); end
  endtask

  task automatic test_x0_drop();
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_addr[0] = 5'd0;
    bus.req_addr[1] = 5'd4;
    bus.req_data[0] = 32'hBAD0;
    bus.req_data[1] = 32'h44;
    #1;
    total++; if (bus.req_ready !== 2'b11) begin bad++; $display("[TB] FAIL x0_ready got=%b exp=11", bus.req_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL x0_busy got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    total++; if (bus.wr_addr !== 5'd4) begin bad++; $display("[TB] FAIL x0_wr_addr got=%0d exp=4", bus.wr_addr); end
    total++; if (bus.wr_data !== 32'h44) begin bad++; $display("[TB] FAIL x0_wr_data got=%h exp=44", bus.wr_data); end
    @(negedge clk);
    bus.req_valid = 2'b01;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL x0_alone_ready got=%b exp=01", bus.req_ready); end
    @(posedge clk); #1;
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL x0_alone_wr_en got=%b exp=0", bus.wr_en); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    total++; if (x0Written !== 1'b0) begin bad++; $display("[TB] FAIL x0_never_written got=%b exp=0", x0Written); end
  endtask

  task automatic test_reset_mid();
`ifdef RF_WB_BYPASS_EN
    bypAddr1 = 5'd6;
    bypAddr2 = 5'd7;
`endif
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_addr[0] = 5'd6;
    bus.req_data[0] = 32'h66;
    @(posedge clk); #1;
    total++; if (bus.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL mid_wr_en_before got=%b exp=1", bus.wr_en); end
    total++; if (bus.wr_addr !== 5'd6) begin bad++; $display("[TB] FAIL mid_wr_addr_before got=%0d exp=6", bus.wr_addr); end
`ifdef RF_WB_BYPASS_EN
    total++; if (bypHit1 !== 1'b1) begin bad++; $display("[TB] FAIL byp_hit1 got=%b exp=1", bypHit1); end
    total++; if (bypHit2 !== 1'b0) begin bad++; $display("[TB] FAIL byp_hit2 got=%b exp=0", bypHit2); end
    total++; if (bypData !== 32'h66) begin bad++; $display("[TB] FAIL byp_data got=%h exp=66", bypData); end
`endif
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_wr_en_async got=%b exp=0", bus.wr_en); end
    total++; if (bus.wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL mid_wr_addr_reset got=%0d exp=0", bus.wr_addr); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("[TB] FAIL mid_ready_reset got=%b exp=00", bus.req_ready); end
`ifdef RF_WB_BYPASS_EN
    total++; if (bypHit1 !== 1'b0) begin bad++; $display("[TB] FAIL byp_hit1_reset got=%b exp=0", bypHit1); end
    total++; if (bypData !== 32'h0) begin bad++; $display("[TB] FAIL byp_data_reset got=%h exp=0", bypData); end
`endif
    @(posedge clk); #1;
    total++; if (rf[6] !== 32'h0) begin bad++; $display("[TB] FAIL mid_reg6_unwritten got=%h exp=0", rf[6]); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_wr_en got=%b exp=0", bus.wr_en); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_alu();
    test_contention();
    test_same_addr();
    test_x0_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
